bt_request_arbiter: RTL and testbench

- Shares the single write port of the BlueTooth controller request FIFO between two byte-stream requesters: requester 0 is the PC UART receive path, requester 1 is the on-chip command generator.
- Grants are frame-atomic. Once a requester is granted, all of its bytes up to and including the byte flagged last go to the FIFO with no interleaving.
- Priority is round-robin between frames.
- A per-frame inactivity timeout releases a grant held by a stalled requester.

---
 rtl/bt_request_arbiter_if.sv | 26 ++
 rtl/bt_request_arbiter.sv | 128 ++++++++++++
 tb/tb_bt_request_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bt_request_arbiter_if.sv
// Requester-side byte streams and FIFO write port of the BlueTooth request arbiter.
// master: the arbiter side; slave: the requesters/FIFO environment.
interface bt_request_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [1:0]              req_vld;
  logic [2*DATA_WIDTH-1:0] req_data;
  logic [1:0]              req_last;
  logic [1:0]              req_rdy;
  logic [DATA_WIDTH-1:0]   fifo_wr_data;
  logic                    fifo_wr_vld;
  logic                    fifo_wr_rdy;
  logic [1:0]              grant;
  logic                    busy;
  logic                    timeout_pulse;

  modport master (
    input  req_vld, req_data, req_last, fifo_wr_rdy,
    output req_rdy, fifo_wr_data, fifo_wr_vld, grant, busy, timeout_pulse
  );

  modport slave (
    output req_vld, req_data, req_last, fifo_wr_rdy,
    input  req_rdy, fifo_wr_data, fifo_wr_vld, grant, busy, timeout_pulse
  );
endinterface

// File: rtl/bt_request_arbiter.sv
// Frame-atomic round-robin arbiter sharing the request FIFO write port between the
// PC UART receive path (requester 0) and the command generator (requester 1).
module bt_request_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_CNT_WIDTH   = 16
) (
  input logic                  clk,
  input logic                  rst,
  bt_request_arbiter_if.master bus
);

  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  // Counter value on the idle cycle that completes the allowed idle budget.
  localparam logic [TO_CNT_WIDTH-1:0] ToLimit = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic {StArb, StXfer} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic                    prio_q, prio_d;
  logic                    out_full_q, out_full_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic [TO_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                    pulse_q, pulse_d;

  logic                  own;
  logic                  own_vld;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  accept_en;
  logic                  in_acc;
  logic                  out_acc;

  assign own      = grant_q[1];
  assign own_vld  = own ? bus.req_vld[1]  : bus.req_vld[0];
  assign own_last = own ? bus.req_last[1] : bus.req_last[0];
  assign own_data = own ? bus.req_data[2*DATA_WIDTH-1:DATA_WIDTH]
                        : bus.req_data[DATA_WIDTH-1:0];

  // Single-entry output register: a new byte is taken only once the previous one left.
  assign accept_en = (state_q == StXfer) && !out_full_q && !done_q;
  assign in_acc    = accept_en && own_vld;
  assign out_acc   = out_full_q && bus.fifo_wr_rdy;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    out_full_d = out_full_q;
    data_d     = data_q;
    done_d     = done_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;
    unique case (state_q)
      StArb: begin
        if (|bus.req_vld) begin
          state_d = StXfer;
          done_d  = 1'b0;
          cnt_d   = '0;
          if (bus.req_vld[prio_q]) begin
            grant_d = prio_q ? 2'b10 : 2'b01;
          end else begin
            grant_d = prio_q ? 2'b01 : 2'b10;
          end
        end
      end
      StXfer: begin
        if (in_acc) begin
          out_full_d = 1'b1;
          data_d     = own_data;
          done_d     = own_last;
          cnt_d      = '0;
        end else if (accept_en) begin
          if (TimeoutEn && (cnt_q == ToLimit)) begin
            state_d = StArb;
            grant_d = 2'b00;
            prio_d  = ~own;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + TO_CNT_WIDTH'(1);
          end
        end
        if (out_acc) begin
          out_full_d = 1'b0;
          if (done_q) begin
            state_d = StArb;
            grant_d = 2'b00;
            prio_d  = ~own;
          end
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StArb;
      grant_q    <= 2'b00;
      prio_q     <= 1'b0;
      out_full_q <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      out_full_q <= out_full_d;
      data_q     <= data_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign bus.req_rdy       = accept_en ? grant_q : 2'b00;
  assign bus.fifo_wr_vld   = out_full_q;
  assign bus.fifo_wr_data  = data_q;
  assign bus.grant         = grant_q;
  assign bus.busy          = (state_q == StXfer);
  assign bus.timeout_pulse = pulse_q;

endmodule

// File: tb/tb_bt_request_arbiter.sv
// Randomized bench for bt_request_arbiter: two random frame producers, random FIFO
// backpressure, a frame-level reference model and an in-order FIFO scoreboard.
module tb_bt_request_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bt_request_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  bt_request_arbiter #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO),
    .TO_CNT_WIDTH  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, the byte waiting for the FIFO, idle count.
  int          m_owner;
  int          m_prio;
  bit          m_full;
  bit          m_done;
  int          m_idle;
  bit          m_pulse;
  logic [7:0]  m_byte;
  logic [7:0]  exp_q[$];

  // Producers: bytes left in the current frame, gap cycles before the next byte.
  int          p_left[2];
  int          p_gap[2];
  logic [7:0]  p_byte[2];
  bit          stall;

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_full  = 0;
    m_done  = 0;
    m_idle  = 0;
    m_pulse = 0;
    m_byte  = '0;
    exp_q.delete();
  endtask

  task automatic prod_reset();
    for (int i = 0; i < 2; i++) begin
      p_left[i] = 0;
      p_gap[i]  = 0;
      p_byte[i] = '0;
    end
    bus.req_vld     = 2'b00;
    bus.req_data    = '0;
    bus.req_last    = 2'b00;
    bus.fifo_wr_rdy = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] vld;
    vld     = bus.req_vld;
    m_pulse = 0;
    if (m_owner < 0) begin
      if (vld != 2'b00) begin
        m_owner = vld[m_prio] ? m_prio : 1 - m_prio;
        m_done  = 0;
        m_idle  = 0;
      end
    end else if (m_full) begin
      if (bus.fifo_wr_rdy) begin
        m_full = 0;
        if (m_done) begin
          m_prio  = 1 - m_owner;
          m_owner = -1;
        end
      end
    end else if (!m_done) begin
      if (vld[m_owner]) begin
        m_full = 1;
        m_byte = bus.req_data[m_owner*DW +: DW];
        m_done = bus.req_last[m_owner];
        m_idle = 0;
        exp_q.push_back(m_byte);
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_prio  = 1 - m_owner;
          m_owner = -1;
          m_pulse = 1;
        end
      end
    end
  endtask

  task automatic drive_next(input logic [1:0] rdy);
    for (int i = 0; i < 2; i++) begin
      if (bus.req_vld[i] && rdy[i]) begin
        p_left[i]--;
        p_byte[i] = 8'($urandom);
        p_gap[i]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 12))
                                                : int'($urandom_range(0, 2));
      end else if (p_gap[i] > 0) begin
        p_gap[i]--;
      end
      if (p_left[i] == 0 && p_gap[i] == 0 && $urandom_range(0, 3) == 0) begin
        p_left[i] = $urandom_range(1, 4);
        p_byte[i] = 8'($urandom);
      end
      bus.req_vld[i]            = (p_left[i] > 0) && (p_gap[i] == 0);
      bus.req_last[i]           = (p_left[i] == 1);
      bus.req_data[i*DW +: DW]  = p_byte[i];
    end
    bus.fifo_wr_rdy = stall ? 1'b0 : ($urandom_range(0, 9) < 7);
  endtask

  task automatic run_cycle();
    logic [1:0] rdy_s;
    logic [1:0] exp_rdy;
    logic [1:0] exp_grant;
    @(negedge clk);
    exp_grant = (m_owner >= 0) ? 2'(2'b01 << m_owner) : 2'b00;
    exp_rdy   = (m_owner >= 0 && !m_full && !m_done) ? exp_grant : 2'b00;
    check_eq("req_rdy", bus.req_rdy, exp_rdy);
    check_eq("grant", bus.grant, exp_grant);
    check_eq("busy", bus.busy, m_owner >= 0);
    check_eq("fifo_wr_vld", bus.fifo_wr_vld, m_full);
    check_eq("fifo_wr_data", bus.fifo_wr_data, m_byte);
    check_eq("timeout_pulse", bus.timeout_pulse, m_pulse);
    if (bus.fifo_wr_vld && bus.fifo_wr_rdy) begin
      if (exp_q.size() == 0) check_eq("fifo_write_unexpected", bus.fifo_wr_vld, 1'b0);
      else check_eq("fifo_order", bus.fifo_wr_data, exp_q.pop_front());
    end
    rdy_s = bus.req_rdy;
    @(posedge clk);
    model_step();
    #1;
    drive_next(rdy_s);
  endtask

  task automatic wait_full(input string tag);
    int n;
    n = 0;
    while (!m_full && n < 400) begin
      run_cycle();
      n++;
    end
    check_eq(tag, bus.fifo_wr_vld, 1'b1);
  endtask

  initial begin
    stall = 0;
    rst   = 1'b1;
    prod_reset();
    model_reset();
    #12;
    check_eq("rst_req_rdy", bus.req_rdy, 2'b00);
    check_eq("rst_grant", bus.grant, 2'b00);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_fifo_wr_vld", bus.fifo_wr_vld, 1'b0);
    check_eq("rst_fifo_wr_data", bus.fifo_wr_data, 8'h00);
    check_eq("rst_timeout_pulse", bus.timeout_pulse, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_next(2'b00);

    repeat (3000) run_cycle();

    // Long FIFO stall with a byte held: data must stay put and no timeout may fire.
    wait_full("bp_reach_full");
    stall = 1;
    repeat (100) run_cycle();
    stall = 0;
    repeat (500) run_cycle();

    // Asynchronous reset while a byte sits in the output register.
    wait_full("rst_reach_full");
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_fifo_wr_vld", bus.fifo_wr_vld, 1'b0);
    check_eq("async_rst_grant", bus.grant, 2'b00);
    check_eq("async_rst_busy", bus.busy, 1'b0);
    model_reset();
    prod_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive_next(2'b00);

    repeat (1000) run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
